// File: rtl/map_generator.sv
// Tile-map background generator for the VGA frame-buffer display.
// Emits one registered 848-pixel line of 2-bit colour codes per requested row.
// Flags when the ant sprite box hits a wall or leaves the screen.
// Counts collisions and shows the count on two active-low hex digits.
module map_generator #(
  parameter int H_PIXELS   = 848,
  parameter int V_PIXELS   = 480,
  parameter int TILE_SHIFT = 4,
  parameter int MAP_COLS   = H_PIXELS >> TILE_SHIFT,
  parameter int MAP_ROWS   = V_PIXELS >> TILE_SHIFT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [8:0]              VPixel,
  input  logic [10:0]             imgX,
  input  logic [10:0]             imgY,
  output logic [2*H_PIXELS-1:0]   mapData,
  output logic                    inBounds,
  output logic [6:0]              HEX0,
  output logic [6:0]              HEX1
);

  localparam logic [1:0] C_FLOOR = 2'd0;
  localparam logic [1:0] C_GOAL  = 2'd1;
  localparam logic [1:0] C_WALL  = 2'd3;

  // Sprite bounding box offsets relative to the anchor.
  localparam logic signed [11:0] BOX_X_LO = 12'sd20;
  localparam logic signed [11:0] BOX_X_HI = 12'sd27;
  localparam logic signed [11:0] BOX_Y_LO = 12'sd23;
  localparam logic signed [11:0] BOX_Y_HI = 12'sd23;
  localparam logic signed [11:0] X_MAX    = 12'(H_PIXELS - 1);
  localparam logic signed [11:0] Y_MAX    = 12'(V_PIXELS - 1);

  // Tile ROM: border walls, a horizontal wall in row 10, one goal tile.
  function automatic logic [1:0] tile_code(input logic [5:0] row, input logic [5:0] col);
    logic [1:0] code;
    code = C_FLOOR;
    if (row == 6'd0 || row == 6'(MAP_ROWS - 1) || col == 6'd0 || col == 6'(MAP_COLS - 1))
      code = C_WALL;
    else if (row == 6'd10 && col >= 6'd10 && col <= 6'd40)
      code = C_WALL;
    else if (row == 6'd25 && col == 6'd48)
      code = C_GOAL;
    return code;
  endfunction

  // Active-low seven-segment glyphs, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [2*H_PIXELS-1:0] r_map_data;
  logic                  r_in_bounds;
  logic [7:0]            r_count;

  logic [2*H_PIXELS-1:0] w_line;
  logic [5:0]            w_row;
  logic signed [11:0]    w_x0, w_x1, w_y0, w_y1;
  logic [5:0]            w_c0, w_c1, w_r0, w_r1;
  logic                  w_edge_hit;
  logic                  w_wall_hit;
  logic                  w_hit;

  assign w_row = {1'b0, VPixel[8:4]};

  // Expand the tile row under VPixel into one line of pixel codes.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    w_line = '0;
    if (VPixel < 9'(V_PIXELS)) begin
      for (int p = 0; p < H_PIXELS; p++)
        w_line[2*p +: 2] = tile_code(w_row, 6'(p >> TILE_SHIFT));
    end
  end

  // Box edges in 12-bit signed arithmetic so negatives are detectable.
  assign w_x0 = $signed({1'b0, imgX}) - BOX_X_LO;
  assign w_x1 = $signed({1'b0, imgX}) + BOX_X_HI;
  assign w_y0 = $signed({1'b0, imgY}) - BOX_Y_LO;
  assign w_y1 = $signed({1'b0, imgY}) + BOX_Y_HI;

  assign w_edge_hit = (w_x0 < 12'sd0) || (w_x1 < 12'sd0) || (w_x0 > X_MAX) || (w_x1 > X_MAX) ||
                      (w_y0 < 12'sd0) || (w_y1 < 12'sd0) || (w_y0 > Y_MAX) || (w_y1 > Y_MAX);

  // Tile coordinates are meaningful only when no edge is off-screen.
  assign w_c0 = w_x0[9:4];
  assign w_c1 = w_x1[9:4];
  assign w_r0 = {1'b0, w_y0[8:4]};
  assign w_r1 = {1'b0, w_y1[8:4]};

  // Scan the (at most 4x4) tiles covered by the box for any wall.
  always_comb begin
    w_wall_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if ((w_c0 + 6'(i)) <= w_c1 && (w_r0 + 6'(j)) <= w_r1 &&
            tile_code(w_r0 + 6'(j), w_c0 + 6'(i)) == C_WALL)
          w_wall_hit = 1'b1;
      end
    end
  end

  assign w_hit = w_edge_hit || w_wall_hit;

  // Register the line data and the collision flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_map_data  <= '0;
      r_in_bounds <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      r_map_data  <= w_line;
      r_in_bounds <= w_hit;
    end
  end

  // Count rising edges of the registered collision flag; wraps 255 -> 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_count <= 8'd0;
    else if (w_hit && !r_in_bounds)
      r_count <= r_count + 8'd1;
  end

  assign mapData  = r_map_data;
  assign inBounds = r_in_bounds;
  assign HEX0     = hex7(r_count[3:0]);
  assign HEX1     = hex7(r_count[7:4]);

endmodule

// File: tb/tb_map_generator.sv
// Directed self-checking bench for map_generator.
module tb_map_generator;

  logic          CLK = 1'b0;
  logic          RST;
  logic [8:0]    VPixel;
  logic [10:0]   imgX;
  logic [10:0]   imgY;
  logic [1695:0] mapData;
  logic          inBounds;
  logic [6:0]    HEX0;
  logic [6:0]    HEX1;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_F = 7'b0001110;

  map_generator dut (
    .CLK(CLK), .RST(RST), .VPixel(VPixel), .imgX(imgX), .imgY(imgY),
    .mapData(mapData), .inBounds(inBounds), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1695:0] fill(input logic [1695:0] base, input int lo,
                                         input int hi, input logic [1:0] code);
    logic [1695:0] v;
    v = base;
    for (int p = lo; p <= hi; p++) v[2*p +: 2] = code;
    return v;
  endfunction

  task automatic check_line(input string tag, input logic [1695:0] exp);
    int bad;
    n_total++;
    assert (mapData === exp) n_pass++;
    else begin
      bad = -1;
      for (int p = 847; p >= 0; p--) if (mapData[2*p +: 2] !== exp[2*p +: 2]) bad = p;
      if (bad < 0) bad = 0;
      $error("FAIL %s: first bad pixel %0d observed %b expected %b", tag, bad,
             mapData[2*bad +: 2], exp[2*bad +: 2]);
    end
  endtask

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    logic [1695:0] exp_line;
    RST = 1'b1; VPixel = 9'd0; imgX = 11'd80; imgY = 11'd80;
    #12;
    check_line("reset_map", '0);
    check_val("reset_inb", {6'd0, inBounds}, 7'd0);
    check_val("reset_hex0", HEX0, SEG_0);
    check_val("reset_hex1", HEX1, SEG_0);
    RST = 1'b0;

    // Row 0: solid wall.
    step();
    check_line("row0_all_wall", {1696{1'b1}});

    // Row 100 -> tile row 6: only border tiles.
    VPixel = 9'd100; step();
    exp_line = fill('0, 0, 15, 2'd3);
    exp_line = fill(exp_line, 832, 847, 2'd3);
    check_line("row100_borders", exp_line);

    // Row 160 -> tile row 10: internal wall over cols 10..40.
    VPixel = 9'd160; step();
    exp_line = fill(exp_line, 160, 655, 2'd3);
    check_line("row160_wall", exp_line);

    // Row 400 -> tile row 25: goal tile at col 48.
    VPixel = 9'd400; step();
    exp_line = fill('0, 0, 15, 2'd3);
    exp_line = fill(exp_line, 832, 847, 2'd3);
    exp_line = fill(exp_line, 768, 783, 2'd1);
    check_line("row400_goal", exp_line);

    // Last visible row is the bottom wall; rows past 479 are blank.
    VPixel = 9'd479; step();
    check_line("row479_wall", {1696{1'b1}});
    VPixel = 9'd480; step();
    check_line("row480_blank", '0);
    VPixel = 9'd500; step();
    check_line("row500_blank", '0);

    // Open floor: no collision.
    step();
    check_val("open_inb", {6'd0, inBounds}, 7'd0);
    check_val("open_hex0", HEX0, SEG_0);

    // Box reaches tile row 0: collision, count 1; holding it counts once.
    imgY = 11'd30; step();
    check_val("top_inb", {6'd0, inBounds}, 7'd1);
    check_val("top_hex0", HEX0, SEG_1);
    step(); step(); step();
    check_val("held_hex0", HEX0, SEG_1);
    check_val("held_hex1", HEX1, SEG_0);

    // Just above the inner wall, then touching it.
    imgX = 11'd200; imgY = 11'd130; step();
    check_val("above_wall_inb", {6'd0, inBounds}, 7'd0);
    imgY = 11'd137; step();
    check_val("touch_wall_inb", {6'd0, inBounds}, 7'd1);

    // Goal tile inside the box does not collide.
    imgX = 11'd790; imgY = 11'd400; step();
    check_val("goal_inb", {6'd0, inBounds}, 7'd0);

    // Left edge at x=-1 collides.
    imgX = 11'd19; imgY = 11'd200; step();
    check_val("left_edge_inb", {6'd0, inBounds}, 7'd1);
    check_val("count3_hex0", HEX0, 7'b0110000);

    // Mid-frame async reset clears outputs without a clock edge.
    VPixel = 9'd0; imgX = 11'd80; imgY = 11'd80; step();
    #2 RST = 1'b1; #1;
    check_line("midrst_map", '0);
    check_val("midrst_inb", {6'd0, inBounds}, 7'd0);
    check_val("midrst_hex0", HEX0, SEG_0);
    #1 RST = 1'b0;
    step();
    check_line("after_rst_map", {1696{1'b1}});

    // 256 separate collisions: checks at 0x1A, 0xFF, then wrap to 0.
    for (int k = 1; k <= 256; k++) begin
      imgY = 11'd30; step();
      imgY = 11'd80; step();
      if (k == 26) begin
        check_val("cnt1a_hex0", HEX0, SEG_A);
        check_val("cnt1a_hex1", HEX1, SEG_1);
      end
      if (k == 255) begin
        check_val("cntff_hex0", HEX0, SEG_F);
        check_val("cntff_hex1", HEX1, SEG_F);
      end
    end
    check_val("wrap_hex0", HEX0, SEG_0);
    check_val("wrap_hex1", HEX1, SEG_0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
